// File: rtl/key_emu_if.sv
// key_emu_if: keypad row/column bus plus host key-request handshake.
`default_nettype none

interface key_emu_if;
  logic [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       busy;
  logic       done;
  logic       pressed;

  modport master (
    output col, key_valid, key_code,
    input  row, key_ready, busy, done, pressed
  );

  modport slave (
    input  col, key_valid, key_code,
    output row, key_ready, busy, done, pressed
  );
endinterface

`default_nettype wire

// File: rtl/key_emu.sv
// ============================================================================
// key_emu : 4x4 matrix-keypad emulator; presses a host-requested key with
//           timed hold/gap and optional contact bounce (KEY_EMU_BOUNCE_EN).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module key_emu #(
  parameter int TICK_DIV  = 50_000,
  parameter int BOUNCE_MS = 4,
  parameter int HOLD_MS   = 40,
  parameter int GAP_MS    = 30
) (
  input  logic      clk,
  input  logic      rst_n,
  key_emu_if.slave  bus
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PM1  = (BOUNCE_MS > HOLD_MS) ? BOUNCE_MS : HOLD_MS;
  localparam int PMAX = (PM1 > GAP_MS) ? PM1 : GAP_MS;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] HOLD_LAST = PW'(HOLD_MS - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_MS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd4;
`ifdef KEY_EMU_BOUNCE_EN
  localparam logic [2:0] S_BOUNCE_IN  = 3'd1;
  localparam logic [2:0] S_BOUNCE_OUT = 3'd3;
  localparam logic [PW-1:0] BOUNCE_LAST = PW'(BOUNCE_MS - 1);
  localparam logic [2:0] S_FIRST = S_BOUNCE_IN;
`else
  localparam logic [2:0] S_FIRST = S_HOLD;
`endif

  logic [2:0]    state, state_nx;
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] ph_cnt;
  logic [1:0]    row_sel, col_sel;
  logic          contact, contact_nx;
  logic          done_q, done_nx;
  logic          ready, accept, tick;
  logic [3:0]    row_drv;

  assign ready  = (state == S_IDLE) && !done_q;
  assign accept = bus.key_valid && ready;
  assign tick   = (state != S_IDLE) && (tick_cnt == TICK_LAST);

  always_comb begin
    state_nx   = state;
    contact_nx = 1'b0;
    done_nx    = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nx = S_FIRST;
`ifdef KEY_EMU_BOUNCE_EN
      S_BOUNCE_IN: begin
        contact_nx = ~ph_cnt[0];
        if (tick && ph_cnt == BOUNCE_LAST) state_nx = S_HOLD;
      end
      S_HOLD: begin
        contact_nx = 1'b1;
        if (tick && ph_cnt == HOLD_LAST) state_nx = S_BOUNCE_OUT;
      end
      S_BOUNCE_OUT: begin
        contact_nx = ph_cnt[0];
        if (tick && ph_cnt == BOUNCE_LAST) state_nx = S_GAP;
      end
`else
      S_HOLD: begin
        contact_nx = 1'b1;
        if (tick && ph_cnt == HOLD_LAST) state_nx = S_GAP;
      end
`endif
      S_GAP: begin
        if (tick && ph_cnt == GAP_LAST) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Contact is registered so the key reads as pressed one clk after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      contact  <= 1'b0;
      done_q   <= 1'b0;
      tick_cnt <= '0;
      ph_cnt   <= '0;
      row_sel  <= 2'd0;
      col_sel  <= 2'd0;
    end else begin
      state   <= state_nx;
      contact <= contact_nx;
      done_q  <= done_nx;
      if (accept) begin
        row_sel  <= bus.key_code[3:2];
        col_sel  <= bus.key_code[1:0];
        tick_cnt <= '0;
        ph_cnt   <= '0;
      end else if (state == S_IDLE) begin
        tick_cnt <= '0;
        ph_cnt   <= '0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (state_nx != state)
          ph_cnt <= '0;
        else if (tick)
          ph_cnt <= ph_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    row_drv = 4'b1111;
    if (contact && !bus.col[col_sel])
      row_drv[row_sel] = 1'b0;
  end

  assign bus.row       = row_drv;
  assign bus.key_ready = ready;
  assign bus.busy      = !ready;
  assign bus.done      = done_q;
  assign bus.pressed   = contact;

endmodule

`default_nettype wire

// File: tb/tb_key_emu.sv
// tb_key_emu: directed checks of key_emu timing, row mapping, request handling and reset.
`default_nettype none

module tb_key_emu;
  localparam int TD = 4;
  localparam int BM = 4;
  localparam int HM = 8;
  localparam int GM = 6;
`ifdef KEY_EMU_BOUNCE_EN
  localparam int EN = 1;
`else
  localparam int EN = 0;
`endif
  localparam int HS  = EN * BM * TD;
  localparam int TOT = (2 * BM * EN + HM + GM) * TD;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   rel   = 0;

  key_emu_if bus ();

  key_emu #(.TICK_DIV(TD), .BOUNCE_MS(BM), .HOLD_MS(HM), .GAP_MS(GM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv_to(input int k);
    while (rel < k) begin
      @(posedge clk); #1;
      rel++;
    end
  endtask

  task automatic accept(input logic [3:0] code);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    @(posedge clk); #1;
    rel = 0;
    bus.key_valid = 1'b0;
  endtask

  initial begin
    logic [4:0] dec;
    logic       seen;
    rst_n = 1'b0;
    bus.col = 4'hF;
    bus.key_valid = 1'b0;
    bus.key_code = 4'h0;
    repeat (3) @(posedge clk); #1;
    chk("rst_row", 8'(bus.row), 8'hF);
    chk("rst_ready", 8'(bus.key_ready), 8'h1);
    chk("rst_busy", 8'(bus.busy), 8'h0);
    chk("rst_done", 8'(bus.done), 8'h0);
    chk("rst_pressed", 8'(bus.pressed), 8'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Code 0, all-zero column
    bus.col = 4'b0000;
    accept(4'd0);
    chk("acc_busy", 8'(bus.busy), 8'h1);
    chk("acc_ready", 8'(bus.key_ready), 8'h0);
    chk("acc_pressed", 8'(bus.pressed), 8'h0);
`ifdef KEY_EMU_BOUNCE_EN
    adv_to(1);  chk("bin0", 8'(bus.pressed), 8'h1); chk("bin0_row", 8'(bus.row), 8'hE);
    adv_to(5);  chk("bin1", 8'(bus.pressed), 8'h0); chk("bin1_row", 8'(bus.row), 8'hF);
    adv_to(9);  chk("bin2", 8'(bus.pressed), 8'h1);
    adv_to(13); chk("bin3", 8'(bus.pressed), 8'h0);
`endif
    adv_to(HS + 1);  chk("hold_start", 8'(bus.pressed), 8'h1); chk("hold_row", 8'(bus.row), 8'hE);
    adv_to(HS + 32); chk("hold_end", 8'(bus.pressed), 8'h1);
    adv_to(HS + 33); chk("after_hold", 8'(bus.pressed), 8'h0); chk("after_hold_row", 8'(bus.row), 8'hF);
    adv_to(TOT - 1); chk("done_early", 8'(bus.done), 8'h0);
    adv_to(TOT);     chk("done_pulse", 8'(bus.done), 8'h1); chk("done_ready", 8'(bus.key_ready), 8'h0);
    adv_to(TOT + 1); chk("done_clear", 8'(bus.done), 8'h0); chk("idle_ready", 8'(bus.key_ready), 8'h1);
    chk("idle_busy", 8'(bus.busy), 8'h0);

    // Code 10
    accept(4'd10);
    adv_to(HS + 1);  chk("c10_row_a", 8'(bus.row), 8'hB);
    adv_to(HS + 32); chk("c10_row_b", 8'(bus.row), 8'hB);
    adv_to(TOT);     chk("c10_done", 8'(bus.done), 8'h1);
    adv_to(TOT + 1);

    // Code 7: column sweep, ignored second request
    accept(4'd7);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd3;
    adv_to(2); chk("ign_ready", 8'(bus.key_ready), 8'h0);
    adv_to(HS + 10);
    bus.col = 4'b0111; #1 chk("sw_0111", 8'(bus.row), 8'hD);
    bus.col = 4'b1011; #1 chk("sw_1011", 8'(bus.row), 8'hF);
    bus.col = 4'b1101; #1 chk("sw_1101", 8'(bus.row), 8'hF);
    bus.col = 4'b1110; #1 chk("sw_1110", 8'(bus.row), 8'hF);
    bus.col = 4'b0000; #1 chk("latched", 8'(bus.row), 8'hD);
    adv_to(TOT);     chk("c7_done", 8'(bus.done), 8'h1); chk("c7_ready", 8'(bus.key_ready), 8'h0);
    adv_to(TOT + 1); chk("c7_ready_rise", 8'(bus.key_ready), 8'h1);
    adv_to(TOT + 2); chk("c3_accept", 8'(bus.busy), 8'h1);
    bus.key_valid = 1'b0;
    rel = 0;
    bus.col = 4'b0111;
    adv_to(HS + 5); chk("c3_row", 8'(bus.row), 8'hE);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Code 15, reset during hold
    bus.col = 4'b0000;
    accept(4'd15);
    adv_to(HS + 5); chk("c15_row", 8'(bus.row), 8'h7);
    rst_n = 1'b0;
    #1;
    chk("arst_row", 8'(bus.row), 8'hF);
    chk("arst_busy", 8'(bus.busy), 8'h0);
    chk("arst_ready", 8'(bus.key_ready), 8'h1);
    chk("arst_pressed", 8'(bus.pressed), 8'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (TOT + 10) begin
      @(posedge clk); #1;
      seen = seen | bus.done;
    end
    chk("arst_no_done", 8'(seen), 8'h0);

    // Loopback: walking-zero scan decodes every code
    for (int code = 0; code < 16; code++) begin
      accept(4'(code));
      adv_to(HS + 5);
      dec = 5'h10;
      for (int c = 0; c < 4; c++) begin
        bus.col = ~(4'b0001 << c);
        #1;
        for (int r = 0; r < 4; r++)
          if (!bus.row[r]) dec = 5'(r * 4 + c);
      end
      chk($sformatf("loop_%0d", code), 8'(dec), 8'(code));
      adv_to(TOT + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
